sysctrl_cfg: RTL
================

SYSCTRL_CFG -- requirements
Module: sysctrl_cfg

Interface
REQ-001 Parameter CORE_ID, default 8'h04, core identifier returned by status command.
REQ-002 Parameter NUM_CFG, default 8, number of 8-bit config slots (legal 1..16).
REQ-003 Parameter CFG_DEFAULTS, default 0, NUM_CFG*8-bit reset values, slot n at bits [8n+7:8n].
REQ-004 Parameter NUM_INT, default 4, interrupt sources (legal 1..7), mapped to pending bits [NUM_INT:1].
REQ-005 Parameter RESET_TIMEOUT, default 75_000_000, cycles before autonomous reset release.
REQ-006 clk  in  1  system clock.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 data_in_strobe  in  1  one-cycle pulse, data_in valid.
REQ-009 data_in_start  in  1  qualifies strobe as the first (command) byte of a transfer.
REQ-010 data_in  in  8  byte from MCU.
REQ-011 data_out  out  8  registered reply byte, read by the MCU during the next byte.
REQ-012 int_out_n  out  1  active-low interrupt to MCU.
REQ-013 int_in  in  NUM_INT  level interrupt sources from the core.
REQ-014 buttons  in  2  board buttons.
REQ-015 leds  out  2  MCU-controlled LEDs.
REQ-016 color  out  24  RGB value for ws2812.
REQ-017 system_reset  out  1  core reset, active high.
REQ-018 cfg_out  out  NUM_CFG*8  config slots, flat bus.

Function
REQ-019 Byte counter: start strobe loads command, counter=1; each later strobe with counter!=0 increments, saturating at 15; bytes before the first start are ignored.
REQ-020 Each command byte is acted on in the cycle of its strobe; data_out updates one clock after that strobe and holds until the next update.
REQ-021 CMD 0 status: bytes 1,2,3,4 load data_out with 8'h5C, 8'h42, CORE_ID, NUM_CFG.
REQ-022 CMD 1: byte 1 bits[1:0] -> leds.
REQ-023 CMD 2: bytes 1,2,3 bit-reversed -> color[15:8], [7:0], [23:16].
REQ-024 CMD 3: every byte loads data_out = {6'b0, buttons}.
REQ-025 CMD 4 config write: byte 1 = slot index, byte 2 = value; index < NUM_CFG writes that slot, index >= NUM_CFG is ignored.
REQ-026 CMD 4 index 8'hFF is reset control: byte 2 bit0 -> system_reset, timeout counter cleared to 0 (cancelled).
REQ-027 CMD 5 interrupt ack: byte 1 = ack mask, clears matching pending bits; every byte loads data_out = pending & {mask[7:1],1'b1}.
REQ-028 CMD 6 config read: byte 1 = index; data_out = slot value, or 8'h00 if index >= NUM_CFG.
REQ-029 CMD 7: byte 1 -> int mask[7:1]; mask bit 0 is fixed 1.
REQ-030 Unknown commands: no state change; data_out holds.
REQ-031 pending[i], i=1..NUM_INT, set on a registered rising edge of int_in[i-1]; set wins over a same-cycle ack.
REQ-032 pending[0] is coldboot, set by reset only, cleared only by ack bit 0; bits above NUM_INT read 0.
REQ-033 int_out_n = 0 when (pending & mask) != 0, else 1; registered.
REQ-034 Timeout counter decrements while nonzero; on the 1->0 transition system_reset drops to 0.
REQ-035 A new start strobe mid-command abandons the previous command; partially written data (e.g. color bytes) stays.

Reset
REQ-036 On reset: counter=0, command=0, leds=0, color=0, data_out=0, cfg_out=CFG_DEFAULTS, pending=8'h01, mask=8'hFF, system_reset=1, timeout=RESET_TIMEOUT, int_out_n=0 from the next cycle; reset overrides all same-cycle strobes.

Verification
REQ-037 Start 0x00, then 4 bytes -> data_out sequence 5C,42,04,08 (defaults).
REQ-038 Reset, no MCU traffic, RESET_TIMEOUT=100 -> system_reset high 100 cycles then 0; CMD4 FF 00 at cycle 10 -> system_reset 0 immediately, counter stopped.
REQ-039 CMD4 03 A5, CMD6 03 xx -> cfg_out[31:24]=A5, read returns A5; CMD4 09 11 (NUM_CFG=8) -> no change, CMD6 09 returns 00.
REQ-040 After reset, int_out_n=0; CMD5 01 -> int_out_n=1; rising int_in[1] -> int_out_n=0, CMD5 reply 04; ack 04 in same cycle as a new edge -> bit stays set.
REQ-041 CMD7 FB masks source 2 -> edge leaves int_out_n=1, CMD5 reply shows 00; unmask -> int_out_n=0.
REQ-042 CMD2 80 01 FF -> color = 24'hFF0180; start strobe after byte 1 -> only color[15:8] updated.

Source files
------------

// File: rtl/sysctrl_cfg.sv
// MCU-facing system controller: byte-command decoder for LEDs, RGB colour, config slots,
// interrupt pending/mask and core reset with autonomous release timeout.
module sysctrl_cfg #(
  parameter logic [7:0]           CORE_ID       = 8'h04,
  parameter int                   NUM_CFG       = 8,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULTS  = '0,
  parameter int                   NUM_INT       = 4,
  parameter int unsigned          RESET_TIMEOUT = 75_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   data_in_strobe,
  input  logic                   data_in_start,
  input  logic [7:0]             data_in,
  output logic [7:0]             data_out,
  output logic                   int_out_n,
  input  logic [NUM_INT-1:0]     int_in,
  input  logic [1:0]             buttons,
  output logic [1:0]             leds,
  output logic [23:0]            color,
  output logic                   system_reset,
  output logic [NUM_CFG*8-1:0]   cfg_out
);

  localparam logic [7:0] NUM_CFG_B  = 8'(NUM_CFG);
  localparam logic [7:0] PEND_VALID = 8'((16'd1 << (NUM_INT + 1)) - 16'd1);

  logic [3:0]           cnt_q, cnt_d;
  logic [7:0]           cmd_q, cmd_d;
  logic [7:0]           idx_q, idx_d;
  logic [1:0]           leds_q, leds_d;
  logic [23:0]          color_q, color_d;
  logic [7:0]           dout_q, dout_d;
  logic [NUM_CFG*8-1:0] cfg_q, cfg_d;
  logic [7:0]           pending_q, pending_d;
  logic [7:0]           mask_q, mask_d;
  logic                 sysrst_q, sysrst_d;
  logic [31:0]          timeout_q, timeout_d;
  logic                 int_n_q, int_n_d;
  logic [NUM_INT-1:0]   int_q, int_d;

  logic       act;
  logic [3:0] byte_n;
  logic [7:0] cmd_cur;
  logic [7:0] ack;
  logic [7:0] rise;
  logic [7:0] rd_val;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  always_comb begin
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    leds_d    = leds_q;
    color_d   = color_q;
    dout_d    = dout_q;
    cfg_d     = cfg_q;
    mask_d    = mask_q;
    sysrst_d  = sysrst_q;
    timeout_d = timeout_q;
    int_d     = int_in;
    act       = 1'b0;
    byte_n    = 4'd0;
    cmd_cur   = cmd_q;
    ack       = 8'h00;
    rise      = 8'h00;
    rd_val    = 8'h00;

    if (timeout_q != 32'd0) begin
      timeout_d = timeout_q - 32'd1;
      if (timeout_q == 32'd1) sysrst_d = 1'b0;
    end

    for (int i = 0; i < NUM_INT; i++) rise[i+1] = int_in[i] & ~int_q[i];

    for (int n = 0; n < NUM_CFG; n++)
      if (data_in == 8'(n)) rd_val = cfg_q[n*8 +: 8];

    // A start strobe always re-arms the decoder, even mid-command.
    if (data_in_strobe && data_in_start) begin
      cmd_d   = data_in;
      cmd_cur = data_in;
      cnt_d   = 4'd1;
      byte_n  = 4'd0;
      act     = 1'b1;
    end else if (data_in_strobe && cnt_q != 4'd0) begin
      cnt_d  = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
      byte_n = cnt_q;
      act    = 1'b1;
    end

    if (act) begin
      case (cmd_cur)
        8'd0: begin
          case (byte_n)
            4'd1:    dout_d = 8'h5C;
            4'd2:    dout_d = 8'h42;
            4'd3:    dout_d = CORE_ID;
            4'd4:    dout_d = NUM_CFG_B;
            default: ;
          endcase
        end
        8'd1: if (byte_n == 4'd1) leds_d = data_in[1:0];
        8'd2: begin
          case (byte_n)
            4'd1:    color_d[15:8]  = rev8(data_in);
            4'd2:    color_d[7:0]   = rev8(data_in);
            4'd3:    color_d[23:16] = rev8(data_in);
            default: ;
          endcase
        end
        8'd3: dout_d = {6'b0, buttons};
        8'd4: begin
          if (byte_n == 4'd1) begin
            idx_d = data_in;
          end else if (byte_n == 4'd2) begin
            if (idx_q == 8'hFF) begin
              sysrst_d  = data_in[0];
              timeout_d = 32'd0;
            end else begin
              for (int n = 0; n < NUM_CFG; n++)
                if (idx_q == 8'(n)) cfg_d[n*8 +: 8] = data_in;
            end
          end
        end
        8'd5: begin
          if (byte_n == 4'd1) ack = data_in;
          dout_d = pending_q & mask_q;
        end
        8'd6: if (byte_n == 4'd1) dout_d = rd_val;
        8'd7: if (byte_n == 4'd1) mask_d = {data_in[7:1], 1'b1};
        default: ;
      endcase
    end

    // Set has priority over a same-cycle acknowledge.
    pending_d = ((pending_q & ~ack) | rise) & PEND_VALID;
    int_n_d   = ~|(pending_q & mask_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      cmd_q     <= 8'd0;
      idx_q     <= 8'd0;
      leds_q    <= 2'd0;
      color_q   <= 24'd0;
      dout_q    <= 8'd0;
      cfg_q     <= CFG_DEFAULTS;
      pending_q <= 8'h01;
      mask_q    <= 8'hFF;
      sysrst_q  <= 1'b1;
      timeout_q <= 32'(RESET_TIMEOUT);
      int_n_q   <= 1'b0;
      int_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      idx_q     <= idx_d;
      leds_q    <= leds_d;
      color_q   <= color_d;
      dout_q    <= dout_d;
      cfg_q     <= cfg_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      sysrst_q  <= sysrst_d;
      timeout_q <= timeout_d;
      int_n_q   <= int_n_d;
      int_q     <= int_d;
    end
  end

  assign data_out     = dout_q;
  assign int_out_n    = int_n_q;
  assign leds         = leds_q;
  assign color        = color_q;
  assign system_reset = sysrst_q;
  assign cfg_out      = cfg_q;

endmodule
